addcmp_checker: RTL and testbench
=================================

# addcmp_checker

Synthesizable self-checking sequencer for the 4-bit add/compare unit. On `start` it drives operand vectors into the unit's `a`, `b` and `Cin` inputs and waits a fixed settle time. It then samples the unit's `Gt`, `Ls` and `Error` outputs, compares them against an internal golden model, and reports a mismatch count plus the first failing vector. It sits on the response side of the adder/comparator, for on-chip BIST and FPGA bring-up.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles between applying a vector and sampling; legal range 1..15.
- `LFSR_SEED`, default 8'hA5: nonzero start state, used only in LFSR mode.

Ports:
- `clk` in 1: sole clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a run; sampled only in IDLE or DONE.
- `cin_cfg` in 1: carry-in used for the whole run; latched when `start` is accepted.
- `dut_a` out 4: operand a to the unit.
- `dut_b` out 4: operand b to the unit.
- `dut_cin` out 1: carry-in to the unit.
- `dut_gt` in 1: unit's Gt output.
- `dut_ls` in 1: unit's Ls output.
- `dut_err` in 1: unit's Error output.
- `busy` out 1: high from APPLY of the first vector through CHECK of the last vector.
- `done` out 1: level; high in DONE.
- `pass` out 1: `done` && `err_count` == 0.
- `err_count` out 9: number of mismatching vectors; saturates at 511.
- `first_fail_a` out 4: a of the first mismatch; 0 if none.
- `first_fail_b` out 4: b of the first mismatch; 0 if none.

## Operation
- Golden model, with `sum` = a + b + cin computed 5 bits wide:
  - `exp_err` = `sum[4]` (carry-out).
  - `exp_gt` = (a > b), unsigned.
  - `exp_ls` = (a < b), unsigned.
  - When a == b, both `exp_gt` and `exp_ls` are 0.
- Mismatch: any of the three sampled bits differs from its expected value. A mismatch counts once per vector, not once per bit.
- Vector order (default mode): 8-bit index i runs 0..255; a = i[7:4], b = i[3:0]. A run is 256 vectors.
- FSM states: IDLE, APPLY, SETTLE, CHECK, DONE.
  - IDLE/DONE + `start` → APPLY. On entry, clear `err_count`, clear both first-fail registers, clear the index and latch `cin_cfg`.
  - APPLY (1 cycle): register the current vector onto `dut_a`, `dut_b` and `dut_cin` → SETTLE.
  - SETTLE: count `SETTLE_CYCLES` cycles → CHECK.
  - CHECK (1 cycle): sample, compare and update counters.
    - On the first mismatch of the run, capture `first_fail_a` and `first_fail_b`.
    - If this was the last vector → DONE; otherwise advance the index → APPLY.
  - DONE: hold all results until the next `start`.
- `start` in APPLY, SETTLE or CHECK is ignored.
- In IDLE, `dut_a`, `dut_b` and `dut_cin` are 0. In DONE they hold the last vector.

## Timing
- Reset: state IDLE; every output 0, including `pass`, `done`, `busy`, `err_count`, both first-fail outputs and all `dut_*` outputs.
- Reset mid-run aborts the run immediately; partial results are discarded.
- `start` high at edge N: APPLY occupies cycle N+1, and `busy` is high from N+1.
- Per vector: 2 + `SETTLE_CYCLES` cycles.
- Full run (default mode): 256 × (2 + `SETTLE_CYCLES`) cycles. `done` rises the cycle after the last CHECK, and `busy` falls in the same cycle.
- Unit inputs are registered, so the unit sees a stable vector for `SETTLE_CYCLES` + 1 edges before sampling.
- `err_count` and the first-fail outputs update at the end of CHECK.
- `start` and restart in the same edge from DONE: the new run starts and the old results clear together.

## Configuration
- `ADDCMP_LFSR_EN` defined:
  - The index comes from an 8-bit Fibonacci LFSR (taps 8,6,5,4), loaded with `LFSR_SEED` on `start`.
  - A run is 255 vectors and ends when the LFSR state returns to the seed.
  - a = state[7:4], b = state[3:0].
- `ADDCMP_LFSR_EN` undefined: exhaustive sweep with a binary counter, 256 vectors. No LFSR logic is synthesized.

## Structure
- Shared package `addcmp_pkg` holds:
  - the state enum typedef;
  - constant `OPW` = 4;
  - constant `VECW` = 8;
  - golden function `addcmp_expect(a, b, cin)`, returning {err, gt, ls}.
- Sub-module `addcmp_vecgen`: takes `clk`, `rst_n`, `load` and `advance`; provides the current 8-bit index and a `last` flag. It contains the counter or the LFSR, selected by `ADDCMP_LFSR_EN`.
- The FSM, result registers and compare logic live in the top level.

## Test plan
- Correct behavioural unit attached, `cin_cfg`=0, `SETTLE_CYCLES`=2, sweep mode:
  - `done` rises after 1024 cycles;
  - `err_count`=0 and `pass`=1;
  - both first-fail outputs are 0.
- Unit with `Gt` stuck at 0, `cin_cfg`=0:
  - `err_count`=120;
  - `first_fail_a`=1, `first_fail_b`=0;
  - `pass`=0.
- Unit with `Error` inverted, `cin_cfg`=1:
  - `err_count`=256;
  - `first_fail_a`=0, `first_fail_b`=0.
- Pulse `start` during SETTLE of vector 10, then assert `rst_n`=0 at vector 100:
  - the extra `start` has no effect;
  - after reset, all outputs are 0 and the state is IDLE;
  - a fresh `start` completes a clean 1024-cycle run.
- Second `start` in DONE after a failing run with a correct unit attached:
  - results clear on acceptance;
  - the final result is `pass`=1.
- `ADDCMP_LFSR_EN`, seed 8'hA5, correct unit attached:
  - exactly 255 vectors, with no index 0 applied;
  - `pass`=1;
  - the first applied vector is a=4'hA, b=4'h5.

Source files
------------

// File: rtl/addcmp_pkg.sv
// addcmp_pkg: shared types, widths and golden model for the add/compare BIST checker.
package addcmp_pkg;
    localparam int OPW = 4;
    localparam int VECW = 8;
    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;
    function automatic logic [2:0] addcmp_expect(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input logic cin);
        logic [OPW:0] sum;
        sum = {1'b0, a} + {1'b0, b} + {{OPW{1'b0}}, cin};
        return {sum[OPW], a > b, a < b};
    endfunction
endpackage

// File: rtl/addcmp_vecgen.sv
// addcmp_vecgen: vector index source; binary sweep by default, 8-bit LFSR when ADDCMP_LFSR_EN is defined.
module addcmp_vecgen
    import addcmp_pkg::*;
#(
    parameter logic [VECW-1:0] LFSR_SEED = 8'hA5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            advance,
    output logic [VECW-1:0] idx,
    output logic            last
);
    if (LFSR_SEED == '0) begin : g_bad_seed
        $error("addcmp_vecgen: LFSR_SEED must be nonzero");
    end
    logic [VECW-1:0] nxt;
`ifdef ADDCMP_LFSR_EN
    localparam logic [VECW-1:0] INIT = LFSR_SEED;
    // taps 8,6,5,4: maximal length, so the run ends when the seed comes round again
    assign nxt  = {idx[6:0], idx[7] ^ idx[5] ^ idx[4] ^ idx[3]};
    assign last = nxt == LFSR_SEED;
`else
    localparam logic [VECW-1:0] INIT = '0;
    assign nxt  = idx + 8'd1;
    assign last = &idx;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idx <= INIT;
        else if (load)
            idx <= INIT;
        else if (advance)
            idx <= nxt;
    end
endmodule

// File: rtl/addcmp_checker.sv
// addcmp_checker: self-checking sequencer for the 4-bit add/compare unit (ADDCMP_LFSR_EN selects LFSR vector order).
module addcmp_checker
    import addcmp_pkg::*;
#(
    parameter int              SETTLE_CYCLES = 2,
    parameter logic [VECW-1:0] LFSR_SEED     = 8'hA5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           cin_cfg,
    output logic [OPW-1:0] dut_a,
    output logic [OPW-1:0] dut_b,
    output logic           dut_cin,
    input  logic           dut_gt,
    input  logic           dut_ls,
    input  logic           dut_err,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [8:0]     err_count,
    output logic [OPW-1:0] first_fail_a,
    output logic [OPW-1:0] first_fail_b
);
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("addcmp_checker: SETTLE_CYCLES must be 1..15");
    end
    state_t          state;
    logic [3:0]      cnt;
    logic            cin_q;
    logic [VECW-1:0] idx;
    logic            last;
    logic            load;
    logic            advance;
    logic            mismatch;
    assign load     = (state == IDLE || state == DONE) && start;
    assign advance  = state == CHECK && !last;
    assign mismatch = {dut_err, dut_gt, dut_ls} != addcmp_expect(dut_a, dut_b, dut_cin);
    assign pass     = done && err_count == '0;
    addcmp_vecgen #(.LFSR_SEED(LFSR_SEED)) u_vecgen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .advance (advance),
        .idx     (idx),
        .last    (last)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            cin_q        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_count    <= '0;
            first_fail_a <= '0;
            first_fail_b <= '0;
            dut_a        <= '0;
            dut_b        <= '0;
            dut_cin      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state        <= APPLY;
                    busy         <= 1'b1;
                    done         <= 1'b0;
                    err_count    <= '0;
                    first_fail_a <= '0;
                    first_fail_b <= '0;
                    cin_q        <= cin_cfg;
                end
                APPLY: begin
                    dut_a   <= idx[7:4];
                    dut_b   <= idx[3:0];
                    dut_cin <= cin_q;
                    cnt     <= '0;
                    state   <= SETTLE;
                end
                SETTLE: begin
                    cnt   <= cnt + 4'd1;
                    state <= cnt == 4'(SETTLE_CYCLES - 1) ? CHECK : SETTLE;
                end
                CHECK: begin
                    // a zero count means no earlier mismatch this run, so this one is the first
                    if (mismatch) begin
                        err_count <= err_count == '1 ? err_count : err_count + 9'd1;
                        if (err_count == '0) begin
                            first_fail_a <= dut_a;
                            first_fail_b <= dut_b;
                        end
                    end
                    state <= last ? DONE : APPLY;
                    busy  <= !last;
                    done  <= last;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_addcmp_checker.sv
// tb_addcmp_checker: randomized fault-injection bench with a behavioural unit and scoreboard model.
module tb_addcmp_checker;
    localparam int S = 2;
    localparam int P = S + 2;
`ifdef ADDCMP_LFSR_EN
    localparam int NV = 255;
`else
    localparam int NV = 256;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic cin_cfg = 1'b0;
    logic [3:0] dut_a, dut_b, first_fail_a, first_fail_b;
    logic dut_cin, dut_gt, dut_ls, dut_err, busy, done, pass;
    logic [8:0] err_count;
    logic [4:0] sum;
    logic [28:0] outs;
    logic [2:0] flip [256];
    int order [$];
    logic [7:0] seen_v [$];
    logic seen_c [$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    addcmp_checker #(.SETTLE_CYCLES(S), .LFSR_SEED(8'hA5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cin_cfg      (cin_cfg),
        .dut_a        (dut_a),
        .dut_b        (dut_b),
        .dut_cin      (dut_cin),
        .dut_gt       (dut_gt),
        .dut_ls       (dut_ls),
        .dut_err      (dut_err),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_count    (err_count),
        .first_fail_a (first_fail_a),
        .first_fail_b (first_fail_b)
    );

    // behavioural add/compare unit; flip[] injects faults per {a,b} vector
    assign sum = 5'(dut_a) + 5'(dut_b) + 5'(dut_cin);
    assign {dut_err, dut_gt, dut_ls} = {sum[4], dut_a > dut_b, dut_a < dut_b} ^ flip[{dut_a, dut_b}];
    assign outs = {busy, done, pass, err_count, first_fail_a, first_fail_b, dut_a, dut_b, dut_cin};

    function automatic void build_order();
`ifdef ADDCMP_LFSR_EN
        int s = 8'hA5;
        for (int j = 0; j < NV; j++) begin
            order.push_back(s);
            s = ((s << 1) | (((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1)) & 255;
        end
`else
        for (int j = 0; j < NV; j++) order.push_back(j);
`endif
    endfunction

    // expected mismatch count and first failing {a,b} in application order
    function automatic void model(output int n, output int ff);
        n = 0;
        ff = 0;
        for (int j = NV - 1; j >= 0; j--)
            if (flip[order[j]] != 3'b0) begin
                n++;
                ff = order[j];
            end
    endfunction

    task automatic set_flips(input int mode);
        for (int i = 0; i < 256; i++)
            flip[i] = mode == 0 ? 3'b000 :
                      mode == 1 ? ((i >> 4) > (i & 15) ? 3'b010 : 3'b000) :
                      mode == 2 ? 3'b100 :
                      ($urandom_range(0, 7) == 0 ? 3'($urandom_range(1, 7)) : 3'b000);
    endtask

    task automatic run(input int glitch_k, input int reset_k, output int cyc);
        bit ok;
        seen_v.delete();
        seen_c.delete();
        cyc = -1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= NV * P + 20; k++) begin
            if (k == 1) begin
                n_cmp++;
                if ({busy, done, err_count, first_fail_a, first_fail_b} !== {1'b1, 18'b0}) begin
                    n_bad++;
                    $display("FAIL accept: busy=%b done=%b err=%0d ff=%h%h, required busy=1 done=0 err=0 ff=00",
                             busy, done, err_count, first_fail_a, first_fail_b);
                end
            end
            if (done === 1'b1) begin
                cyc = k - 1;
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL busy_fall: busy=%b with done high, required 0", busy);
                end
                break;
            end
            if (k >= 2 && (k - 2) % P == 0) begin
                seen_v.push_back({dut_a, dut_b});
                seen_c.push_back(dut_cin);
            end
            if (k == reset_k) begin
                rst_n = 1'b0;
                break;
            end
            start = k == glitch_k;
            @(negedge clk);
        end
        start = 1'b0;
        if (reset_k == 0) begin
            n_cmp++;
            if (cyc < 0) begin
                n_bad++;
                $display("FAIL timeout: done never rose within %0d cycles", NV * P + 20);
            end
        end
        ok = cyc < 0 || seen_v.size() == NV;
        foreach (seen_v[j]) ok &= j < NV && seen_v[j] == 8'(order[j]) && seen_c[j] == cin_cfg;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL order: %0d vectors seen, first=%h, required %0d vectors in model order with cin=%b",
                     seen_v.size(), seen_v.size() > 0 ? seen_v[0] : 8'h0, NV, cin_cfg);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (outs !== '0) begin
            n_bad++;
            $display("FAIL reset_outs: got %h, required 0", outs);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (outs !== '0) begin
            n_bad++;
            $display("FAIL idle_outs: got %h, required 0", outs);
        end
    endtask

    task automatic test_clean();
        int cyc, n, ff;
        bit zero_seen;
        set_flips(0);
        cin_cfg = 1'b0;
        run(0, 0, cyc);
        model(n, ff);
        zero_seen = 0;
        foreach (seen_v[j]) zero_seen |= seen_v[j] == 8'h00;
        n_cmp++;
        if (cyc != NV * P) begin
            n_bad++;
            $display("FAIL clean_cycles: got %0d, required %0d", cyc, NV * P);
        end
        n_cmp++;
        if ({pass, err_count, first_fail_a, first_fail_b} !== {1'b1, 9'(n), 8'(ff)}) begin
            n_bad++;
            $display("FAIL clean_result: pass=%b err=%0d ff=%h%h, required pass=1 err=0 ff=00",
                     pass, err_count, first_fail_a, first_fail_b);
        end
`ifdef ADDCMP_LFSR_EN
        n_cmp++;
        if (seen_v.size() == 0 || seen_v[0] !== 8'hA5 || zero_seen) begin
            n_bad++;
            $display("FAIL lfsr_first: first=%h zero_seen=%b, required first=a5 zero_seen=0",
                     seen_v.size() > 0 ? seen_v[0] : 8'h0, zero_seen);
        end
`else
        n_cmp++;
        if (seen_v.size() == 0 || seen_v[0] !== 8'h00 || !zero_seen) begin
            n_bad++;
            $display("FAIL sweep_first: first=%h, required 00", seen_v.size() > 0 ? seen_v[0] : 8'h0);
        end
`endif
    endtask

    task automatic test_gt_stuck();
        int cyc, n, ff;
        set_flips(1);
        cin_cfg = 1'b0;
        run(0, 0, cyc);
        model(n, ff);
        n_cmp++;
        if (err_count !== 9'd120 || n != 120) begin
            n_bad++;
            $display("FAIL gt_count: got %0d, required 120", err_count);
        end
        n_cmp++;
        if ({pass, first_fail_a, first_fail_b} !== {1'b0, 8'(ff)}) begin
            n_bad++;
            $display("FAIL gt_first: pass=%b ff=%h%h, required pass=0 ff=%h", pass, first_fail_a, first_fail_b, 8'(ff));
        end
    endtask

    task automatic test_err_inv();
        int cyc, n, ff;
        set_flips(2);
        cin_cfg = 1'b1;
        run(0, 0, cyc);
        model(n, ff);
        n_cmp++;
        if ({pass, err_count, first_fail_a, first_fail_b} !== {1'b0, 9'(NV), 8'(order[0])}) begin
            n_bad++;
            $display("FAIL err_inv: pass=%b err=%0d ff=%h%h, required pass=0 err=%0d ff=%h",
                     pass, err_count, first_fail_a, first_fail_b, NV, 8'(order[0]));
        end
    endtask

    task automatic test_random();
        int cyc, n, ff;
        for (int r = 0; r < 3; r++) begin
            set_flips(3);
            cin_cfg = 1'($urandom_range(0, 1));
            run(0, 0, cyc);
            model(n, ff);
            n_cmp++;
            if ({pass, err_count, first_fail_a, first_fail_b} !== {n == 0, 9'(n), 8'(ff)}) begin
                n_bad++;
                $display("FAIL random%0d: pass=%b err=%0d ff=%h%h, required pass=%b err=%0d ff=%h",
                         r, pass, err_count, first_fail_a, first_fail_b, n == 0, n, 8'(ff));
            end
        end
    endtask

    task automatic test_glitch_reset();
        int cyc;
        set_flips(2);
        cin_cfg = 1'b0;
        run(10 * P + 2, 100 * P + 2, cyc);
        #1;
        n_cmp++;
        if (outs !== '0) begin
            n_bad++;
            $display("FAIL midrun_reset: got %h, required 0", outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_flips(0);
        run(0, 0, cyc);
        n_cmp++;
        if (cyc != NV * P || pass !== 1'b1 || err_count !== 9'd0) begin
            n_bad++;
            $display("FAIL post_reset_run: cycles=%0d pass=%b err=%0d, required cycles=%0d pass=1 err=0",
                     cyc, pass, err_count, NV * P);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        set_flips(3);
        flip[order[5]] = 3'b001;
        cin_cfg = 1'b1;
        run(0, 0, cyc);
        n_cmp++;
        if (pass !== 1'b0 || err_count === 9'd0) begin
            n_bad++;
            $display("FAIL b2b_first: pass=%b err=%0d, required pass=0 err>0", pass, err_count);
        end
        set_flips(0);
        run(0, 0, cyc);
        n_cmp++;
        if ({pass, err_count, first_fail_a, first_fail_b} !== {1'b1, 17'b0}) begin
            n_bad++;
            $display("FAIL b2b_second: pass=%b err=%0d ff=%h%h, required pass=1 err=0 ff=00",
                     pass, err_count, first_fail_a, first_fail_b);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) flip[i] = 3'b0;
        build_order();
        test_reset();
        test_clean();
        test_gt_stuck();
        test_err_inv();
        test_random();
        test_glitch_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
